// File: rtl/btb_predictor.sv
// btb_predictor: set-associative branch target buffer with saturating
// direction counters, round-robin replacement and an optional return stack.
//
// Fetch side (combinational): PC -> PRD_HIT / PRD_TAKEN / PRD_ADDR.
// Update side: UPD_* and FLUSH are captured on adv (CACHE_READY &
// CACHE_READY_DATA) and committed on the next adv. LOOKUPS and MISPRED
// count committed updates and committed mispredictions.
//
// Ports: CLK, RST_N (async low), CACHE_READY, CACHE_READY_DATA, PC,
//   PRD_HIT, PRD_TAKEN, PRD_ADDR, UPD_VALID, UPD_PC, UPD_TAKEN, UPD_TARGET,
//   UPD_CALL, UPD_RETURN, FLUSH, LOOKUPS, MISPRED.
//
// Build option: define BTB_RAS_EN to add the return address stack.
module btb_predictor #(
  parameter int ADDR_WIDTH = 32,
  parameter int SETS       = 256,
  parameter int WAYS       = 2,
  parameter int CNT_WIDTH  = 2,
  parameter int RAS_DEPTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CACHE_READY,
  input  logic                  CACHE_READY_DATA,
  input  logic [ADDR_WIDTH-1:0] PC,
  output logic                  PRD_HIT,
  output logic                  PRD_TAKEN,
  output logic [ADDR_WIDTH-1:0] PRD_ADDR,
  input  logic                  UPD_VALID,
  input  logic [ADDR_WIDTH-1:0] UPD_PC,
  input  logic                  UPD_TAKEN,
  input  logic [ADDR_WIDTH-1:0] UPD_TARGET,
  input  logic                  UPD_CALL,
  input  logic                  UPD_RETURN,
  input  logic                  FLUSH,
  output logic [31:0]           LOOKUPS,
  output logic [31:0]           MISPRED
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(1) << (CNT_WIDTH - 1);

  logic adv;
  assign adv = CACHE_READY & CACHE_READY_DATA;

  // storage: only valid bits and rr pointers are reset
  logic [SETS-1:0][WAYS-1:0] vld_q;
  logic [WAY_W-1:0]          rr_q  [SETS];
  logic [TAG_W-1:0]          tag_q [SETS][WAYS];
  logic [ADDR_WIDTH-1:0]     tgt_q [SETS][WAYS];
  logic [CNT_WIDTH-1:0]      cnt_q [SETS][WAYS];

  // capture register
  logic                  u_vld, u_taken, u_flush, u_call, u_ret;
  logic [ADDR_WIDTH-1:0] u_pc, u_tgt;
  logic [31:0]           lookups_q, mispred_q;

  // ---------------- lookup ----------------
  logic [IDX_W-1:0] l_set, u_set;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic [WAYS-1:0]  l_match, u_match;
  assign l_set = PC[IDX_W+1:2];
  assign l_tag = PC[ADDR_WIDTH-1:IDX_W+2];
  assign u_set = u_pc[IDX_W+1:2];
  assign u_tag = u_pc[ADDR_WIDTH-1:IDX_W+2];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign l_match[w] = vld_q[l_set][w] && (tag_q[l_set][w] == l_tag);
    assign u_match[w] = vld_q[u_set][w] && (tag_q[u_set][w] == u_tag);
  end

  // lowest matching way wins; scan high-to-low so the last write is the lowest
  logic             l_hit, u_hit;
  logic [WAY_W-1:0] l_way, u_way, a_way;
  always_comb begin
    l_hit = 1'b0;
    l_way = '0;
    u_hit = 1'b0;
    u_way = '0;
    a_way = rr_q[u_set];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (l_match[w]) begin
        l_hit = 1'b1;
        l_way = WAY_W'(w);
      end
      if (u_match[w]) begin
        u_hit = 1'b1;
        u_way = WAY_W'(w);
      end
      if (!vld_q[u_set][w]) a_way = WAY_W'(w);
    end
  end

  // ---------------- return stack ----------------
`ifdef BTB_RAS_EN
  localparam int RP_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  logic                  ret_q   [SETS][WAYS];
  logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [RP_W-1:0]       ras_ptr;   // next free slot; top is ras_ptr-1
  logic [RP_W:0]         ras_cnt;
  logic [ADDR_WIDTH-1:0] ras_top;
  logic                  do_push, do_pop;
  assign ras_top = ras_mem[ras_ptr - 1'b1];
`endif

  // ---------------- prediction ----------------
  always_comb begin
    PRD_HIT   = l_hit;
    PRD_TAKEN = l_hit & cnt_q[l_set][l_way][CNT_WIDTH-1];
    PRD_ADDR  = PC + ADDR_WIDTH'(4);
    if (PRD_HIT && cnt_q[l_set][l_way][CNT_WIDTH-1]) PRD_ADDR = tgt_q[l_set][l_way];
`ifdef BTB_RAS_EN
    if (l_hit && ret_q[l_set][l_way] && ras_cnt != '0) begin
      PRD_TAKEN = 1'b1;
      PRD_ADDR  = ras_top;
    end
`endif
  end

  // ---------------- commit ----------------
  logic                 commit, st_taken, mis;
  logic [CNT_WIDTH-1:0] u_cnt, cnt_nxt;
  assign commit   = adv & u_vld & ~u_flush;
  assign u_cnt    = cnt_q[u_set][u_way];
  assign st_taken = u_hit & u_cnt[CNT_WIDTH-1];
  assign mis      = (st_taken != u_taken) ||
                    (u_taken && st_taken && tgt_q[u_set][u_way] != u_tgt);

  always_comb begin
    cnt_nxt = u_cnt;
    if (u_taken) begin
      if (u_cnt != CNT_MAX) cnt_nxt = u_cnt + 1'b1;
    end else begin
      if (u_cnt != '0) cnt_nxt = u_cnt - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_q     <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
      u_vld     <= 1'b0;
      u_taken   <= 1'b0;
      u_flush   <= 1'b0;
      u_call    <= 1'b0;
      u_ret     <= 1'b0;
      u_pc      <= '0;
      u_tgt     <= '0;
      lookups_q <= '0;
      mispred_q <= '0;
    end else begin
      if (adv) begin
        u_vld   <= UPD_VALID;
        u_taken <= UPD_TAKEN;
        u_flush <= FLUSH;
        u_call  <= UPD_CALL;
        u_ret   <= UPD_RETURN;
        u_pc    <= UPD_PC;
        u_tgt   <= UPD_TARGET;
      end
      if (commit) begin
        lookups_q <= lookups_q + 32'd1;
        if (mis) mispred_q <= mispred_q + 32'd1;
        if (!u_hit && u_taken) begin
          vld_q[u_set][a_way] <= 1'b1;
          rr_q[u_set]         <= (WAYS > 1) ? rr_q[u_set] + 1'b1 : '0;
        end
      end
    end
  end

  // unreset payload arrays
  always_ff @(posedge CLK) begin
    if (commit) begin
      if (u_hit) begin
        cnt_q[u_set][u_way] <= cnt_nxt;
        if (u_taken) tgt_q[u_set][u_way] <= u_tgt;
`ifdef BTB_RAS_EN
        ret_q[u_set][u_way] <= u_ret;
`endif
      end else if (u_taken) begin
        tag_q[u_set][a_way] <= u_tag;
        tgt_q[u_set][a_way] <= u_tgt;
        cnt_q[u_set][a_way] <= CNT_INIT;
`ifdef BTB_RAS_EN
        ret_q[u_set][a_way] <= u_ret;
`endif
      end
    end
  end

`ifdef BTB_RAS_EN
  // call+return together: pop then push, i.e. the top entry is replaced
  assign do_pop  = commit & u_ret & (ras_cnt != '0);
  assign do_push = commit & u_call;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (do_push && !do_pop) begin
      ras_ptr <= ras_ptr + 1'b1;
      if (ras_cnt != (RP_W+1)'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
    end else if (do_pop && !do_push) begin
      ras_ptr <= ras_ptr - 1'b1;
      ras_cnt <= ras_cnt - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) begin
      if (do_pop) ras_mem[ras_ptr - 1'b1] <= u_pc + ADDR_WIDTH'(4);
      else        ras_mem[ras_ptr]        <= u_pc + ADDR_WIDTH'(4);
    end
  end
`else
  logic unused_upd;
  assign unused_upd = ^{u_call, u_ret, u_pc[1:0]};
`endif

  assign LOOKUPS = lookups_q;
  assign MISPRED = mispred_q;
endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: directed checks of btb_predictor at default parameters
// (SETS=256, WAYS=2, CNT_WIDTH=2). Return-stack checks run when BTB_RAS_EN
// is defined; otherwise returns must predict from the stored target.
module tb_btb_predictor;
  logic        CLK = 1'b0;
  logic        RST_N, CACHE_READY, CACHE_READY_DATA;
  logic [31:0] PC;
  logic        PRD_HIT, PRD_TAKEN;
  logic [31:0] PRD_ADDR;
  logic        UPD_VALID, UPD_TAKEN, UPD_CALL, UPD_RETURN, FLUSH;
  logic [31:0] UPD_PC, UPD_TARGET;
  logic [31:0] LOOKUPS, MISPRED;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  btb_predictor dut (
    .CLK(CLK), .RST_N(RST_N), .CACHE_READY(CACHE_READY),
    .CACHE_READY_DATA(CACHE_READY_DATA), .PC(PC),
    .PRD_HIT(PRD_HIT), .PRD_TAKEN(PRD_TAKEN), .PRD_ADDR(PRD_ADDR),
    .UPD_VALID(UPD_VALID), .UPD_PC(UPD_PC), .UPD_TAKEN(UPD_TAKEN),
    .UPD_TARGET(UPD_TARGET), .UPD_CALL(UPD_CALL), .UPD_RETURN(UPD_RETURN),
    .FLUSH(FLUSH), .LOOKUPS(LOOKUPS), .MISPRED(MISPRED)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic tk, input logic [31:0] addr);
    PC = pc;
    #1;
    chk({tag, ".hit"}, {31'd0, PRD_HIT}, {31'd0, hit});
    chk({tag, ".taken"}, {31'd0, PRD_TAKEN}, {31'd0, tk});
    chk({tag, ".addr"}, PRD_ADDR, addr);
  endtask

  task automatic cnts(input string tag, input int l, input int m);
    chk({tag, ".lookups"}, LOOKUPS, l);
    chk({tag, ".mispred"}, MISPRED, m);
  endtask

  // capture on one edge, commit on the next
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic call, input logic ret, input logic fl);
    UPD_VALID = 1'b1; UPD_PC = pc; UPD_TAKEN = tk; UPD_TARGET = tgt;
    UPD_CALL = call; UPD_RETURN = ret; FLUSH = fl;
    @(posedge CLK); #1;
    UPD_VALID = 1'b0; UPD_CALL = 1'b0; UPD_RETURN = 1'b0; FLUSH = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    RST_N = 1'b0; CACHE_READY = 1'b1; CACHE_READY_DATA = 1'b1; PC = 32'h100;
    UPD_VALID = 1'b0; UPD_PC = '0; UPD_TAKEN = 1'b0; UPD_TARGET = '0;
    UPD_CALL = 1'b0; UPD_RETURN = 1'b0; FLUSH = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK); #1;

    // reset state and PC+4 wrap
    look("rst", 32'h100, 0, 0, 32'h104);
    cnts("rst", 0, 0);
    look("wrap", 32'hFFFF_FFFC, 0, 0, 32'h0);

    // first allocation: miss+taken is a mispredict, counter starts weakly taken
    upd(32'h100, 1, 32'h400, 0, 0, 0);
    look("alloc", 32'h100, 1, 1, 32'h400);
    cnts("alloc", 1, 1);

    // counter walk 2->1->0, then up to saturation at 3
    upd(32'h100, 0, 0, 0, 0, 0);
    look("nt1", 32'h100, 1, 0, 32'h104);
    upd(32'h100, 0, 0, 0, 0, 0);
    look("nt2", 32'h100, 1, 0, 32'h104);
    cnts("nt2", 3, 2);
    for (int i = 0; i < 4; i++) upd(32'h100, 1, 32'h400, 0, 0, 0);
    look("sat", 32'h100, 1, 1, 32'h400);
    cnts("sat", 7, 4);
    // from 3 one not-taken leaves it taken (would not if it had wrapped)
    upd(32'h100, 0, 0, 0, 0, 0);
    look("sat_dn", 32'h100, 1, 1, 32'h400);
    cnts("sat_dn", 8, 5);
    // predicted taken but target changed: mispredict, target replaced
    upd(32'h100, 1, 32'h480, 0, 0, 0);
    look("retgt", 32'h100, 1, 1, 32'h480);
    cnts("retgt", 9, 6);

    // three taken branches in set 0x40 with two ways: third evicts way 0
    upd(32'h500, 1, 32'h600, 0, 0, 0);
    upd(32'h900, 1, 32'hA00, 0, 0, 0);
    look("evict_a", 32'h100, 0, 0, 32'h104);
    look("evict_b", 32'h500, 1, 1, 32'h600);
    look("evict_c", 32'h900, 1, 1, 32'hA00);
    cnts("evict", 11, 8);
    // miss and not taken: counted, no allocation, no mispredict
    upd(32'hD00, 0, 32'hE00, 0, 0, 0);
    look("nt_miss", 32'hD00, 0, 0, 32'hD04);
    look("nt_miss_b", 32'h500, 1, 1, 32'h600);
    cnts("nt_miss", 12, 8);

    // flushed update: no state change, not counted
    upd(32'h500, 0, 0, 0, 0, 1);
    look("flush", 32'h500, 1, 1, 32'h600);
    cnts("flush", 12, 8);

    // stall: captured update waits while adv=0; new update is not captured
    UPD_VALID = 1'b1; UPD_PC = 32'h900; UPD_TAKEN = 1'b0; UPD_TARGET = '0;
    @(posedge CLK); #1;
    CACHE_READY_DATA = 1'b0;
    UPD_PC = 32'hD00; UPD_TAKEN = 1'b1; UPD_TARGET = 32'hE00;
    repeat (5) @(posedge CLK);
    #1;
    look("hold", 32'h900, 1, 1, 32'hA00);
    cnts("hold", 12, 8);
    UPD_VALID = 1'b0;
    CACHE_READY_DATA = 1'b1;
    @(posedge CLK); #1;
    look("release", 32'h900, 1, 0, 32'h904);
    cnts("release", 13, 9);
    look("no_capt", 32'hD00, 0, 0, 32'hD04);

`ifdef BTB_RAS_EN
    // learn a return first (pop on empty ignored), then a call pushes 0x204
    upd(32'h300, 1, 32'h700, 0, 1, 0);
    upd(32'h200, 1, 32'h800, 1, 0, 0);
    look("ras_ret", 32'h300, 1, 1, 32'h204);
    upd(32'h300, 1, 32'h700, 0, 1, 0);
    look("ras_empty", 32'h300, 1, 1, 32'h700);
    // 9 pushes into depth 8: oldest overwritten
    for (int k = 0; k < 9; k++) upd(32'h2000 + 32'(4 * k), 0, 0, 1, 0, 0);
    look("ras_full", 32'h300, 1, 1, 32'h2024);
    for (int k = 0; k < 7; k++) upd(32'h300, 1, 32'h700, 0, 1, 0);
    look("ras_pop7", 32'h300, 1, 1, 32'h2008);
    upd(32'h300, 1, 32'h700, 0, 1, 0);
    look("ras_pop8", 32'h300, 1, 1, 32'h700);
    upd(32'h300, 1, 32'h700, 0, 1, 0);   // ignored
    upd(32'h3000, 0, 0, 1, 0, 0);
    look("ras_push1", 32'h300, 1, 1, 32'h3004);
    upd(32'h300, 1, 32'h700, 0, 1, 0);
    look("ras_pop9", 32'h300, 1, 1, 32'h700);
`else
    // without the stack, call/return flags are ignored
    upd(32'h300, 1, 32'h700, 0, 1, 0);
    upd(32'h200, 1, 32'h800, 1, 0, 0);
    look("noras_ret", 32'h300, 1, 1, 32'h700);
    look("noras_call", 32'h200, 1, 1, 32'h800);
`endif

    // reset with an update pending: everything cleared, update dropped
    UPD_VALID = 1'b1; UPD_PC = 32'h100; UPD_TAKEN = 1'b1; UPD_TARGET = 32'h400;
    @(posedge CLK); #1;
    UPD_VALID = 1'b0;
    RST_N = 1'b0;
    #1;
    look("mid_rst", 32'h500, 0, 0, 32'h504);
    cnts("mid_rst", 0, 0);
    #1 RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    look("dropped", 32'h100, 0, 0, 32'h104);
    cnts("dropped", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
